// File: rtl/des_key_sched.sv
// DES key schedule: generates the 16 round subkeys, one per accepted request.
// Ports:
//   clk_in              clock, all state updates on its rising edge
//   rst_in              synchronous active-high reset
//   key_in              64-bit DES key (standard bit 1 = key_in[63]), parity ignored
//   key_in_valid        load key_in and start a new schedule
//   decrypt_in          sampled on load: 1 = issue K16..K1, 0 = K1..K16
//   round_req_in        request the next subkey (one per asserted cycle)
//   key_data_out        48-bit round subkey (PC-2 output, bit 1 = [47])
//   key_data_out_valid  one-cycle pulse marking a new subkey
//   round_out           issue index of the subkey on key_data_out
//   sched_done_out      high once all 16 subkeys have been issued
module des_key_sched (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] key_in,
  input  logic        key_in_valid,
  input  logic        decrypt_in,
  input  logic        round_req_in,
  output logic [47:0] key_data_out,
  output logic        key_data_out_valid,
  output logic [3:0]  round_out,
  output logic        sched_done_out
);

  localparam int unsigned KEY_W  = 64;
  localparam int unsigned HALF_W = 28;
  localparam int unsigned CD_W   = 56;
  localparam int unsigned SUB_W  = 48;
  localparam int unsigned CNT_W  = 4;

  // PC-1: entry i is the 1-based key bit that lands in CD bit i+1
  localparam int unsigned PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry i is the 1-based CD bit that lands in subkey bit i+1
  localparam int unsigned PC2 [SUB_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Bit n set when the encrypt rotation for issue n is 2 places, else 1
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dec_q, dec_d;
  logic [SUB_W-1:0]    key_q, key_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    round_q, round_d;
  logic                done_q, done_d;

  logic [CD_W-1:0]     pc1_c;
  logic [HALF_W-1:0]   rot_c, rot_d;
  logic [CNT_W-1:0]    dec_idx;
  logic                two;

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1[i])];
    end
    return r;
  endfunction

  function automatic logic [SUB_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SUB_W-1:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    end
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic by2);
    return by2 ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic by2);
    return by2 ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  assign pc1_c = pc1(key_in);

  // Decrypt issue n undoes encrypt shift S[16-n]; 16-n mod 16 is the 4-bit negation
  assign dec_idx = 4'(4'd0 - cnt_q);

  // State and output registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      key_q   <= '0;
      valid_q <= 1'b0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // Next-state: a load always wins; requests only act in RUN
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    key_d   = key_q;
    valid_d = 1'b0;
    round_d = round_q;
    done_d  = done_q;
    rot_c   = c_q;
    rot_d   = d_q;
    two     = 1'b0;

    if (key_in_valid) begin
      c_d     = pc1_c[55:28];
      d_d     = pc1_c[27:0];
      dec_d   = decrypt_in;
      cnt_d   = '0;
      done_d  = 1'b0;
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE: begin
        end
        RUN: begin
          if (round_req_in) begin
            if (dec_q) begin
              // Issue 0 of a decrypt schedule is K16, which needs no rotation
              if (cnt_q != '0) begin
                two   = SHIFT2[dec_idx];
                rot_c = rotr(c_q, two);
                rot_d = rotr(d_q, two);
              end
            end else begin
              two   = SHIFT2[cnt_q];
              rot_c = rotl(c_q, two);
              rot_d = rotl(d_q, two);
            end
            c_d     = rot_c;
            d_d     = rot_d;
            key_d   = pc2({rot_c, rot_d});
            valid_d = 1'b1;
            round_d = cnt_q;
            if (cnt_q == 4'd15) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign key_data_out       = key_q;
  assign key_data_out_valid = valid_q;
  assign round_out          = round_q;
  assign sched_done_out     = done_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: known-answer subkeys for the classic
// key 133457799BBCDFF1, scoreboard popped by a monitor on each valid pulse.
module tb_des_key_sched;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [63:0] key_in;
  logic        key_in_valid;
  logic        decrypt_in;
  logic        round_req_in;
  logic [47:0] key_data_out;
  logic        key_data_out_valid;
  logic [3:0]  round_out;
  logic        sched_done_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  rnd;
    logic        done;
  } exp_t;

  exp_t sb[$];

  localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_B = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [47:0] ALL1  = 48'hFFFFFFFFFFFF;

  // K1..K16 of KEY_A, stored at index 0..15
  localparam logic [47:0] KS [16] = '{
    48'b000110_110000_001011_101111_111111_000111_000001_110010,
    48'b011110_011010_111011_011001_110110_111100_100111_100101,
    48'b010101_011111_110010_001010_010000_101100_111110_011001,
    48'b011100_101010_110111_010110_110110_110011_010100_011101,
    48'b011111_001110_110000_000111_111010_110101_001110_101000,
    48'b011000_111010_010100_111110_010100_000111_101100_101111,
    48'b111011_001000_010010_110111_111101_100001_100010_111100,
    48'b111101_111000_101000_111010_110000_010011_101111_111011,
    48'b111000_001101_101111_101011_111011_011110_011110_000001,
    48'b101100_011111_001101_000111_101110_100100_011001_001111,
    48'b001000_010101_111111_010011_110111_101101_001110_000110,
    48'b011101_010111_000111_110101_100101_000110_011111_101001,
    48'b100101_111100_010111_010001_111110_101011_101001_000001,
    48'b010111_110100_001110_110111_111100_101110_011100_111010,
    48'b101111_111001_000110_001101_001111_010011_111100_001010,
    48'b110010_110011_110110_001011_000011_100001_011111_110101
  };

  des_key_sched dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .key_in             (key_in),
    .key_in_valid       (key_in_valid),
    .decrypt_in         (decrypt_in),
    .round_req_in       (round_req_in),
    .key_data_out       (key_data_out),
    .key_data_out_valid (key_data_out_valid),
    .round_out          (round_out),
    .sched_done_out     (sched_done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
    #1;
  endtask

  // Pops one expected subkey on every valid pulse
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (key_data_out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: key=%h round=%0d, required no pulse", key_data_out, round_out);
        end else begin
          e = sb.pop_front();
          vectors++;
          if (key_data_out !== e.key) begin
            miscompares++;
            $display("FAIL subkey: got %h, required %h (round %0d)", key_data_out, e.key, e.rnd);
          end
          vectors++;
          if (round_out !== e.rnd) begin
            miscompares++;
            $display("FAIL round_out: got %0d, required %0d", round_out, e.rnd);
          end
          vectors++;
          if (sched_done_out !== e.done) begin
            miscompares++;
            $display("FAIL done_with_issue: got %b, required %b (round %0d)", sched_done_out, e.done, e.rnd);
          end
        end
      end
    end
  endtask

  task automatic load(input logic [63:0] k, input logic dec);
    key_in       = k;
    decrypt_in   = dec;
    key_in_valid = 1'b1;
    tick();
    key_in_valid = 1'b0;
  endtask

  task automatic req_cycle(input logic [47:0] k, input int n);
    exp_t e;
    e.key  = k;
    e.rnd  = 4'(n);
    e.done = (n == 15);
    round_req_in = 1'b1;
    sb.push_back(e);
    tick();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
    sample();
    vectors++;
    if (key_data_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", key_data_out_valid); end
    vectors++;
    if (key_data_out !== 48'h0) begin miscompares++; $display("FAIL reset_key: got %h, required 0", key_data_out); end
    vectors++;
    if (round_out !== 4'd0) begin miscompares++; $display("FAIL reset_round: got %0d, required 0", round_out); end
    vectors++;
    if (sched_done_out !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, required 0", sched_done_out); end
  endtask

  task automatic test_encrypt();
    load(KEY_A, 1'b0);
    sample();
    vectors++;
    if (sched_done_out !== 1'b0 || key_data_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL enc_after_load: done=%b valid=%b, required 0 0", sched_done_out, key_data_out_valid);
    end
    for (int n = 0; n < 16; n++) req_cycle(KS[n], n);
    round_req_in = 1'b0;
    sample();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL enc_drain: %0d pending, required 0", sb.size()); end
    tick();
    sample();
    vectors++;
    if (key_data_out_valid !== 1'b0 || sched_done_out !== 1'b1) begin
      miscompares++;
      $display("FAIL enc_after_done: valid=%b done=%b, required 0 1", key_data_out_valid, sched_done_out);
    end
    vectors++;
    if (key_data_out !== KS[15] || round_out !== 4'd15) begin
      miscompares++;
      $display("FAIL enc_hold: key=%h round=%0d, required %h 15", key_data_out, round_out, KS[15]);
    end
  endtask

  task automatic test_decrypt();
    load(KEY_A, 1'b1);
    sample();
    vectors++;
    if (sched_done_out !== 1'b0) begin miscompares++; $display("FAIL dec_done_fall: got %b, required 0", sched_done_out); end
    vectors++;
    if (key_data_out !== KS[15] || round_out !== 4'd15 || key_data_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_hold: key=%h round=%0d valid=%b, required %h 15 0", key_data_out, round_out, key_data_out_valid, KS[15]);
    end
    for (int n = 0; n < 16; n++) req_cycle(KS[15 - n], n);
    round_req_in = 1'b0;
    sample();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL dec_drain: %0d pending, required 0", sb.size()); end
    vectors++;
    if (sched_done_out !== 1'b1) begin miscompares++; $display("FAIL dec_done: got %b, required 1", sched_done_out); end
  endtask

  task automatic test_sparse();
    int g;
    load(KEY_A, 1'b0);
    for (int n = 0; n < 16; n++) begin
      req_cycle(KS[n], n);
      round_req_in = 1'b0;
      sample();
      vectors++;
      if (sb.size() != 0) begin miscompares++; $display("FAIL sparse_latency: issue %0d not seen, %0d pending", n, sb.size()); end
      g = $urandom_range(0, 5);
      repeat (g) begin
        tick();
        sample();
        vectors++;
        if (key_data_out_valid !== 1'b0 || key_data_out !== KS[n] || round_out !== 4'(n)) begin
          miscompares++;
          $display("FAIL sparse_hold: valid=%b key=%h round=%0d, required 0 %h %0d", key_data_out_valid, key_data_out, round_out, KS[n], n);
        end
      end
    end
  endtask

  task automatic test_reload();
    load(KEY_A, 1'b0);
    for (int n = 0; n < 5; n++) req_cycle(KS[n], n);
    key_in       = KEY_B;
    decrypt_in   = 1'b0;
    key_in_valid = 1'b1;
    round_req_in = 1'b1;
    tick();
    key_in_valid = 1'b0;
    round_req_in = 1'b0;
    sample();
    vectors++;
    if (key_data_out_valid !== 1'b0 || round_out !== 4'd4 || key_data_out !== KS[4]) begin
      miscompares++;
      $display("FAIL reload_no_issue: valid=%b round=%0d key=%h, required 0 4 %h", key_data_out_valid, round_out, key_data_out, KS[4]);
    end
    req_cycle(ALL1, 0);
    round_req_in = 1'b0;
    sample();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL reload_first: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    load(KEY_A, 1'b0);
    for (int n = 0; n < 7; n++) req_cycle(KS[n], n);
    rst_in       = 1'b1;
    round_req_in = 1'b1;
    tick();
    rst_in       = 1'b0;
    round_req_in = 1'b0;
    sample();
    vectors++;
    if (key_data_out_valid !== 1'b0 || key_data_out !== 48'h0 || round_out !== 4'd0 || sched_done_out !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b key=%h round=%0d done=%b, required all 0", key_data_out_valid, key_data_out, round_out, sched_done_out);
    end
    round_req_in = 1'b1;
    tick();
    round_req_in = 1'b0;
    sample();
    vectors++;
    if (key_data_out_valid !== 1'b0 || key_data_out !== 48'h0 || round_out !== 4'd0) begin
      miscompares++;
      $display("FAIL req_after_reset: valid=%b key=%h round=%0d, required 0 0 0", key_data_out_valid, key_data_out, round_out);
    end
    load(KEY_A, 1'b0);
    req_cycle(KS[0], 0);
    round_req_in = 1'b0;
    sample();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL reset_reload: %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_idle_done();
    rst_in = 1'b1;
    tick();
    rst_in       = 1'b0;
    round_req_in = 1'b1;
    tick();
    tick();
    round_req_in = 1'b0;
    sample();
    vectors++;
    if (key_data_out_valid !== 1'b0 || key_data_out !== 48'h0 || round_out !== 4'd0 || sched_done_out !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_req: valid=%b key=%h round=%0d done=%b, required all 0", key_data_out_valid, key_data_out, round_out, sched_done_out);
    end
    // Parity-only key: every non-parity bit set, so every subkey is all ones
    load(KEY_B, 1'b1);
    for (int n = 0; n < 16; n++) req_cycle(ALL1, n);
    round_req_in = 1'b0;
    sample();
    round_req_in = 1'b1;
    tick();
    tick();
    round_req_in = 1'b0;
    sample();
    vectors++;
    if (key_data_out_valid !== 1'b0 || key_data_out !== ALL1 || round_out !== 4'd15 || sched_done_out !== 1'b1) begin
      miscompares++;
      $display("FAIL done_req: valid=%b key=%h round=%0d done=%b, required 0 %h 15 1", key_data_out_valid, key_data_out, round_out, sched_done_out, ALL1);
    end
  endtask

  initial begin
    rst_in       = 1'b0;
    key_in       = '0;
    key_in_valid = 1'b0;
    decrypt_in   = 1'b0;
    round_req_in = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_encrypt();
    test_decrypt();
    test_sparse();
    test_reload();
    test_reset_mid();
    test_idle_done();
    tick();
    tick();
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL final_drain: %0d pending, required 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
